// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Output end of the audio path. Accepts a stereo sample pair through a
//   valid/ready handshake into a one-pair holding buffer and transmits it to
//   the DAC as Philips I2S. BCLK and LRCLK are derived from clk. When the
//   producer falls behind, the last frame is repeated and underrun is flagged.
//
// Parameters
//   DATA_W     sample width (two's complement, MSB first)
//   SLOT_W     BCLK periods per channel slot (>= DATA_W+1), padding bits are 0
//   BCLK_HALF  clk cycles per BCLK half period (>= 2)
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   lft_smpl       left sample, captured on accept
//   rght_smpl      right sample, captured on accept
//   smpl_vld       sample pair valid
//   smpl_rdy       holding buffer empty (accept = smpl_vld & smpl_rdy)
//   clr_underrun   clears the sticky underrun flag
//   BCLK           I2S bit clock
//   LRCLK          I2S word select (0 = left, 1 = right)
//   SDATA          I2S serial data, updated on BCLK falling edge
//   frm_strt       1-clk pulse when a new pair is loaded from the buffer
//   underrun       sticky, set on a frame load with an empty buffer
module i2s_tx_serializer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_smpl,
  input  logic [DATA_W-1:0] rght_smpl,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  input  logic              clr_underrun,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              SDATA,
  output logic              frm_strt,
  output logic              underrun
);

  localparam int unsigned FRM_BITS = 2 * SLOT_W;
  localparam int unsigned CW       = $clog2(FRM_BITS);
  localparam int unsigned DVW      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0]  K_LAST   = CW'(FRM_BITS - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(BCLK_HALF - 1);

  logic [DVW-1:0]    div_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     k_nxt;
  logic              hold_full;
  logic              first_load;
  logic [DATA_W-1:0] hold_lft;
  logic [DATA_W-1:0] hold_rght;
  logic [DATA_W-1:0] lft_frm;
  logic [DATA_W-1:0] rght_frm;

  logic              fall_evt;
  logic              frm_load;
  logic              accept;
  logic              sdata_nxt;
  logic              lr_nxt;
  int unsigned       k_i;
  logic [IW-1:0]     lidx;
  logic [IW-1:0]     ridx;

  assign fall_evt = (div_cnt == DIV_LAST) && BCLK;
  assign frm_load = fall_evt && (bit_cnt == K_LAST);
  assign accept   = smpl_vld && smpl_rdy;
  assign k_nxt    = (bit_cnt == K_LAST) ? '0 : bit_cnt + CW'(1);

  // Serial bit for the slot position about to start. At a frame load the next
  // position is 0, which is always padding, so reading the frame regs before
  // they are refreshed is harmless.
  always_comb begin
    k_i       = 32'(k_nxt);
    lidx      = IW'(DATA_W - k_i);
    ridx      = IW'(SLOT_W + DATA_W - k_i);
    sdata_nxt = 1'b0;
    if (k_i >= 1 && k_i <= DATA_W) begin
      sdata_nxt = lft_frm[lidx];
    end else if (k_i >= SLOT_W + 1 && k_i <= SLOT_W + DATA_W) begin
      sdata_nxt = rght_frm[ridx];
    end
    lr_nxt = (k_i >= SLOT_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= K_LAST;
      BCLK       <= 1'b0;
      LRCLK      <= 1'b0;
      SDATA      <= 1'b0;
      frm_strt   <= 1'b0;
      underrun   <= 1'b0;
      smpl_rdy   <= 1'b1;
      hold_full  <= 1'b0;
      first_load <= 1'b1;
      hold_lft   <= '0;
      hold_rght  <= '0;
      lft_frm    <= '0;
      rght_frm   <= '0;
    end else begin
      frm_strt <= 1'b0;

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        BCLK    <= ~BCLK;
      end else begin
        div_cnt <= div_cnt + DVW'(1);
      end

      if (fall_evt) begin
        bit_cnt <= k_nxt;
        LRCLK   <= lr_nxt;
        SDATA   <= sdata_nxt;
      end

      // Clear first so that a simultaneous underrun set wins.
      if (clr_underrun) begin
        underrun <= 1'b0;
      end

      if (frm_load) begin
        first_load <= 1'b0;
        if (hold_full) begin
          lft_frm   <= hold_lft;
          rght_frm  <= hold_rght;
          hold_full <= 1'b0;
          smpl_rdy  <= 1'b1;
          frm_strt  <= 1'b1;
        end else if (!first_load) begin
          underrun <= 1'b1;
        end
      end

      // Accept needs an empty buffer and a load only drains a full one, so the
      // two never update hold_full on the same clk. No bypass into the frame.
      if (accept) begin
        hold_lft  <= lft_smpl;
        hold_rght <= rght_smpl;
        hold_full <= 1'b1;
        smpl_rdy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
//   Directed bench for i2s_tx_serializer at default parameters. A monitor
//   captures each transmitted frame (SDATA/LRCLK at every BCLK rise, plus
//   frm_strt/underrun at the load clk) indexed by clk count since reset
//   release; a vector table holds the per-frame stimulus and expected results.
module tb_i2s_tx_serializer;

  localparam int FRM = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic        smpl_vld;
  logic        smpl_rdy;
  logic        clr_underrun;
  logic        BCLK;
  logic        LRCLK;
  logic        SDATA;
  logic        frm_strt;
  logic        underrun;

  i2s_tx_serializer #(
    .DATA_W   (16),
    .SLOT_W   (32),
    .BCLK_HALF(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lft_smpl    (lft_smpl),
    .rght_smpl   (rght_smpl),
    .smpl_vld    (smpl_vld),
    .smpl_rdy    (smpl_rdy),
    .clr_underrun(clr_underrun),
    .BCLK        (BCLK),
    .LRCLK       (LRCLK),
    .SDATA       (SDATA),
    .frm_strt    (frm_strt),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Posedges since reset release: edge 1 is the first edge with rst low.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Frame capture
  logic [63:0] cap_d  [0:15];
  logic [63:0] cap_lr [0:15];
  logic        cap_fs [0:15];
  logic        cap_und[0:15];
  int          fbase   = 0;
  int          tim_err = 0;

  always @(negedge clk) begin
    int rel, n, k;
    logic exp_b;
    exp_b = (cyc >= 4) ? (((cyc - 4) % 8) < 4) : 1'b0;
    if (BCLK !== exp_b) tim_err++;
    if (cyc >= 8) begin
      rel = cyc - 8;
      n   = fbase + rel / FRM;
      if (n < 16) begin
        if (rel % FRM == 0) begin
          cap_fs[n]  = frm_strt;
          cap_und[n] = underrun;
        end else if (frm_strt !== 1'b0) begin
          tim_err++;
        end
        if (rel % 8 == 4) begin
          k = (rel % FRM) / 8;
          cap_d[n][k]  = SDATA;
          cap_lr[n][k] = LRCLK;
        end
      end
    end else if (frm_strt !== 1'b0) begin
      tim_err++;
    end
  end

  function automatic int load_at(input int n);
    return 8 + FRM * n;
  endfunction

  function automatic logic [63:0] exp_bits(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = '0;
    for (int k = 1; k <= 16; k++) begin
      v[k]      = l[16-k];
      v[32 + k] = r[16-k];
    end
    return v;
  endfunction

  task automatic wait_cyc(input int t);
    for (int g = 0; g < 3000 && cyc < t; g++) @(negedge clk);
    if (cyc < t) begin
      n_chk++;
      $display("FAIL wait_cyc: reached %0d, required %0d", cyc, t);
    end
  endtask

  // Present a pair from the current negedge until accepted; acc_at is the
  // posedge number on which the accept happened.
  task automatic offer(input logic [15:0] l, input logic [15:0] r, input bit keep,
                       output int acc_at);
    logic r0;
    lft_smpl  = l;
    rght_smpl = r;
    smpl_vld  = 1'b1;
    r0        = smpl_rdy;
    acc_at    = -1;
    for (int g = 0; g < 1200 && acc_at < 0; g++) begin
      @(negedge clk);
      if (r0) acc_at = cyc;
      else    r0 = smpl_rdy;
    end
    if (!keep) smpl_vld = 1'b0;
    chk("accept_seen", acc_at >= 0, 1);
  endtask

  typedef enum logic [2:0] {S_NONE, S_OFFER, S_PAIR2, S_CLR_OFFER, S_CLR_AT_LOAD, S_EXACT} stim_e;

  typedef struct {
    stim_e       stim;   // stimulus applied during this frame
    logic [15:0] l, r;   // pair offered
    logic [15:0] l2, r2; // second pair (S_PAIR2)
    logic        fs;     // expected frm_strt at this frame's load
    logic        und;    // expected underrun just after this frame's load
    logic [15:0] el, er; // expected transmitted pair
  } vec_t;

  vec_t tab[10];

  initial begin
    int a;
    logic r0;

    rst          = 1'b1;
    smpl_vld     = 1'b0;
    clr_underrun = 1'b0;
    lft_smpl     = '0;
    rght_smpl    = '0;

    tab[0] = '{S_PAIR2,       16'h1234, 16'hFEDC, 16'h0001, 16'h8000, 1'b1, 1'b0, 16'hA5C3, 16'h8001};
    tab[1] = '{S_NONE,        16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hFEDC};
    tab[2] = '{S_NONE,        16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h8000};
    tab[3] = '{S_CLR_OFFER,   16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h8000};
    tab[4] = '{S_CLR_AT_LOAD, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 16'hFFFF};
    tab[5] = '{S_EXACT,       16'h0F0F, 16'hF0F0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h7FFF, 16'hFFFF};
    tab[6] = '{S_NONE,        16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h7FFF, 16'hFFFF};
    tab[7] = '{S_OFFER,       16'h5A5A, 16'hA5A5, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0};
    // Frames 8 and 9 follow the mid-frame reset.
    tab[8] = '{S_OFFER,       16'hC001, 16'h3FFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tab[9] = '{S_NONE,        16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hC001, 16'h3FFE};

    repeat (3) @(negedge clk);
    chk("rst_bclk",     BCLK,     0);
    chk("rst_lrclk",    LRCLK,    0);
    chk("rst_sdata",    SDATA,    0);
    chk("rst_smpl_rdy", smpl_rdy, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_frm_strt", frm_strt, 0);

    rst = 1'b0;
    offer(16'hA5C3, 16'h8001, 1'b0, a);
    chk("first_accept_edge", a, 1);

    for (int i = 0; i < 8; i++) begin
      wait_cyc(load_at(i) + 10);
      case (tab[i].stim)
        S_OFFER: offer(tab[i].l, tab[i].r, 1'b0, a);
        S_PAIR2: begin
          offer(tab[i].l, tab[i].r, 1'b1, a);
          chk("rdy_low_while_full", smpl_rdy, 0);
          offer(tab[i].l2, tab[i].r2, 1'b0, a);
          chk("second_accept_edge", a, load_at(i + 1) + 1);
        end
        S_CLR_OFFER: begin
          clr_underrun = 1'b1;
          @(negedge clk);
          clr_underrun = 1'b0;
          chk("underrun_cleared", underrun, 0);
          offer(tab[i].l, tab[i].r, 1'b0, a);
        end
        S_CLR_AT_LOAD: begin
          wait_cyc(load_at(i + 1) - 1);
          clr_underrun = 1'b1;
          @(negedge clk);
          clr_underrun = 1'b0;
          chk("underrun_set_beats_clr", underrun, 1);
          wait_cyc(load_at(i + 1) + 20);
          clr_underrun = 1'b1;
          @(negedge clk);
          clr_underrun = 1'b0;
          chk("underrun_recleared", underrun, 0);
        end
        S_EXACT: begin
          wait_cyc(load_at(i + 1) - 1);
          lft_smpl  = tab[i].l;
          rght_smpl = tab[i].r;
          smpl_vld  = 1'b1;
          r0        = smpl_rdy;
          @(negedge clk);
          smpl_vld = 1'b0;
          chk("exact_load_rdy", r0, 1);
          chk("exact_accept_fills", smpl_rdy, 0);
        end
        default: ;
      endcase
    end

    // Fill the buffer, then reset at bit 20 of frame 8's left slot.
    wait_cyc(load_at(8) + 10);
    offer(16'hDEAD, 16'hBEEF, 1'b0, a);
    wait_cyc(load_at(8) + 8 * 20 + 4);
    chk("pre_rst_rdy",      smpl_rdy, 0);
    chk("pre_rst_underrun", underrun, 1);
    chk("pre_rst_bclk",     BCLK,     1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_bclk",     BCLK,     0);
    chk("mid_rst_lrclk",    LRCLK,    0);
    chk("mid_rst_sdata",    SDATA,    0);
    chk("mid_rst_smpl_rdy", smpl_rdy, 1);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_frm_strt", frm_strt, 0);
    fbase = 8;
    rst   = 1'b0;

    wait_cyc(load_at(0) + 10);
    offer(tab[8].l, tab[8].r, 1'b0, a);
    wait_cyc(load_at(2) + 2);

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("frm%0d_frm_strt", i), cap_fs[i],  tab[i].fs);
      chk($sformatf("frm%0d_underrun", i), cap_und[i], tab[i].und);
      chk($sformatf("frm%0d_sdata", i),    cap_d[i],   exp_bits(tab[i].el, tab[i].er));
      chk($sformatf("frm%0d_lrclk", i),    cap_lr[i],  {32'hFFFF_FFFF, 32'h0000_0000});
    end
    chk("bclk_frm_strt_timing_errors", tim_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
